symbol_mux_821: RTL

SYMBOL_MUX_821 -- requirements
Module: symbol_mux_821

---
 rtl/symbol_pkg.sv | 17 +
 rtl/symbol_sel_mux.sv | 19 +
 rtl/symbol_mux_821.sv | 106 ++++++++++
 3 files changed

// File: rtl/symbol_pkg.sv
// Shared definitions for the byte-to-symbol serializer.
package symbol_pkg;

    // Symbol width used when an instance does not override it.
    localparam int SYM_W_DEFAULT = 4;

    // Width of one input byte (two symbols).
    localparam int BYTE_W = 2 * SYM_W_DEFAULT;

    // Serializer states: no byte held, low symbol presented, high symbol presented.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } sm_state_t;

endpackage

// File: rtl/symbol_sel_mux.sv
// Combinational 2:1 symbol selector: sel=0 picks the low half, sel=1 the high half.
module symbol_sel_mux #(
    parameter int SYM_W = 4
) (
    input  logic [SYM_W-1:0] lo,
    input  logic [SYM_W-1:0] hi,
    input  logic             sel,
    output logic [SYM_W-1:0] data
);

    genvar gi;
    generate
        for (gi = 0; gi < SYM_W; gi++) begin : g_bit
            // Per-bit select so the mux maps directly onto LUTs.
            assign data[gi] = sel ? hi[gi] : lo[gi];
        end
    endgenerate

endmodule

// File: rtl/symbol_mux_821.sv
// Byte-to-symbol serializer: each accepted byte is emitted as two symbols,
// low half first, with zero-bubble handoff between consecutive bytes.
module symbol_mux_821
    import symbol_pkg::*;
#(
    parameter int SYM_W = SYM_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2*SYM_W-1:0] inData,
    input  logic               inValid,
    input  logic               inLast,
    output logic               inReady,
    output logic [SYM_W-1:0]   outData,
    output logic               outSel,
    output logic               outValid,
    output logic               outLast,
    input  logic               outReady
);

    sm_state_t          state_reg, state_next;
    logic [2*SYM_W-1:0] byte_reg, byte_next;
    logic               last_reg, last_next;

    logic               ready_int;
    logic               valid_int;
    logic               sel_int;
    logic               last_out_int;
    logic [SYM_W-1:0]   mux_data;

    // Next-state and output decode; the held byte is only replaced on an input transfer.
    always_comb begin
        state_next   = state_reg;
        byte_next    = byte_reg;
        last_next    = last_reg;
        ready_int    = 1'b0;
        valid_int    = 1'b0;
        sel_int      = 1'b0;
        last_out_int = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_int = 1'b1;
                if (inValid) begin
                    byte_next  = inData;
                    last_next  = inLast;
                    state_next = LOW;
                end
            end
            LOW: begin
                valid_int = 1'b1;
                if (outReady) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                valid_int    = 1'b1;
                sel_int      = 1'b1;
                last_out_int = last_reg;
                // Accept the next byte only when the high symbol leaves this cycle.
                ready_int    = outReady;
                if (outReady) begin
                    if (inValid) begin
                        byte_next  = inData;
                        last_next  = inLast;
                        state_next = LOW;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and held-byte registers with synchronous reset that drops any held byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            byte_reg  <= '0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            byte_reg  <= byte_next;
            last_reg  <= last_next;
        end
    end

    symbol_sel_mux #(
        .SYM_W (SYM_W)
    ) u_sel_mux (
        .lo   (byte_reg[SYM_W-1:0]),
        .hi   (byte_reg[2*SYM_W-1:SYM_W]),
        .sel  (sel_int),
        .data (mux_data)
    );

    // Outputs are forced quiet for the whole time reset is held.
    assign inReady  = ready_int    & ~reset;
    assign outValid = valid_int    & ~reset;
    assign outSel   = sel_int      & ~reset;
    assign outLast  = last_out_int & ~reset;
    assign outData  = reset ? '0 : mux_data;

endmodule
